// File: rtl/tx_pkg.sv
// Shared definitions for the transmit puncturer: rate codes, puncture masks,
// pattern periods and the packet FSM state encoding.
package tx_pkg;

    localparam logic [1:0] RATE_1_2  = 2'd0;
    localparam logic [1:0] RATE_2_3  = 2'd1;
    localparam logic [1:0] RATE_3_4  = 2'd2;
    localparam logic [1:0] RATE_RSVD = 2'd3;

    // Bit p of a mask = keep that coded bit when the pattern phase is p.
    localparam logic [2:0] MASK_A_1_2 = 3'b111;
    localparam logic [2:0] MASK_B_1_2 = 3'b111;
    localparam logic [2:0] MASK_A_2_3 = 3'b011;
    localparam logic [2:0] MASK_B_2_3 = 3'b001;
    localparam logic [2:0] MASK_A_3_4 = 3'b011;
    localparam logic [2:0] MASK_B_3_4 = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic logic [1:0] rate_period(input logic [1:0] rate);
        case (rate)
            RATE_2_3: rate_period = 2'd2;
            RATE_3_4: rate_period = 2'd3;
            default:  rate_period = 2'd1;
        endcase
    endfunction

    function automatic logic [2:0] punct_mask_a(input logic [1:0] rate);
        case (rate)
            RATE_2_3: punct_mask_a = MASK_A_2_3;
            RATE_3_4: punct_mask_a = MASK_A_3_4;
            default:  punct_mask_a = MASK_A_1_2;
        endcase
    endfunction

    function automatic logic [2:0] punct_mask_b(input logic [1:0] rate);
        case (rate)
            RATE_2_3: punct_mask_b = MASK_B_2_3;
            RATE_3_4: punct_mask_b = MASK_B_3_4;
            default:  punct_mask_b = MASK_B_1_2;
        endcase
    endfunction

endpackage

// File: rtl/puncture_compact.sv
// Combinational puncture of one coded beat: drops bits by rate/phase and
// packs the survivors LSB-first, returning the kept count and next phase.
module puncture_compact
    import tx_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int KW    = $clog2(2 * WIDTH + 1)
) (
    input  logic [2*WIDTH-1:0] data_i,
    input  logic [1:0]         rate_i,
    input  logic [1:0]         phase_i,
    output logic [2*WIDTH-1:0] kept_o,
    output logic [KW-1:0]      count_o,
    output logic [1:0]         phase_o
);

    logic [2:0] mask_a;
    logic [2:0] mask_b;
    logic [1:0] last_phase;

    assign mask_a     = punct_mask_a(rate_i);
    assign mask_b     = punct_mask_b(rate_i);
    assign last_phase = rate_period(rate_i) - 2'd1;

    always_comb begin
        kept_o  = '0;
        count_o = '0;
        phase_o = phase_i;
        for (int i = 0; i < WIDTH; i++) begin
            if (mask_a[phase_o]) begin
                kept_o  = kept_o | ((2*WIDTH)'(data_i[2*i]) << count_o);
                count_o = count_o + 1'b1;
            end
            if (mask_b[phase_o]) begin
                kept_o  = kept_o | ((2*WIDTH)'(data_i[2*i+1]) << count_o);
                count_o = count_o + 1'b1;
            end
            phase_o = (phase_o == last_phase) ? 2'd0 : phase_o + 2'd1;
        end
    end

endmodule

// File: rtl/tx_puncturer.sv
// Rate-adaptive puncturer with output gearbox: punctures coded beats and
// repacks survivors into OUT_WIDTH-bit AXI-Stream beats, zero-padding the tail.
module tx_puncturer
    import tx_pkg::*;
#(
    parameter  int WIDTH     = 24,
    parameter  int OUT_WIDTH = 24,
    localparam int CW        = $clog2(OUT_WIDTH + 1)
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [2*WIDTH-1:0]   s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic [3:0]           s_axis_tuser,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [3:0]           m_axis_tuser,
    output logic [CW-1:0]        m_axis_tcount,
    output logic [1:0]           dbg_state_o
);

    localparam int AW = 2 * OUT_WIDTH + 2 * WIDTH;
    localparam int FW = $clog2(AW + 1);
    localparam int KW = $clog2(2 * WIDTH + 1);

    // Handshake: a beat moves on a channel in any cycle where tvalid and
    // tready are both high at the rising edge of aclk; tvalid never waits
    // for tready, and neither tready looks at either tvalid.

    state_t        state_q;
    logic [AW-1:0] acc_q, acc_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [1:0]    phase_q;
    logic [1:0]    rate_q;
    logic [3:0]    tuser_q;

    logic [1:0]         cur_rate;
    logic [1:0]         cur_phase;
    logic [2*WIDTH-1:0] kept;
    logic [KW-1:0]      kept_cnt;
    logic [1:0]         next_phase;
    logic               fill_ge_out;
    logic [FW-1:0]      out_cnt;
    logic               m_valid_int;
    logic               m_last_int;
    logic               s_ready_int;
    logic               push;
    logic               pop;

    // The first beat of a packet uses its own rate field and starts at phase 0.
    assign cur_rate  = (state_q == IDLE) ? s_axis_tuser[1:0] : rate_q;
    assign cur_phase = (state_q == IDLE) ? 2'd0 : phase_q;

    puncture_compact #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_compact (
        .data_i  (s_axis_tdata),
        .rate_i  (cur_rate),
        .phase_i (cur_phase),
        .kept_o  (kept),
        .count_o (kept_cnt),
        .phase_o (next_phase)
    );

    assign fill_ge_out = (fill_q >= FW'(OUT_WIDTH));
    assign out_cnt     = fill_ge_out ? FW'(OUT_WIDTH) : fill_q;
    assign m_valid_int = !areset && (fill_ge_out || (state_q == FLUSH && fill_q != '0));
    assign m_last_int  = !areset && (state_q == FLUSH) && (fill_q <= FW'(OUT_WIDTH));
    assign s_ready_int = !areset && (state_q != FLUSH) &&
                         ((fill_q < FW'(OUT_WIDTH)) ||
                          (m_axis_tready && (fill_q < FW'(2 * OUT_WIDTH))));
    assign push = s_axis_tvalid && s_ready_int;
    assign pop  = m_valid_int && m_axis_tready;

    // Bits above fill are always zero, so a shift-down plus OR-in is enough.
    always_comb begin
        acc_d  = acc_q;
        fill_d = fill_q;
        if (pop) begin
            acc_d  = acc_q >> out_cnt;
            fill_d = fill_q - out_cnt;
        end
        if (push) begin
            acc_d  = acc_d | (AW'(kept) << fill_d);
            fill_d = fill_d + FW'(kept_cnt);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            fill_q  <= '0;
            phase_q <= 2'd0;
            rate_q  <= 2'd0;
            tuser_q <= 4'd0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
            if (push) begin
                phase_q <= next_phase;
            end
            case (state_q)
                IDLE: begin
                    if (push) begin
                        rate_q  <= s_axis_tuser[1:0];
                        tuser_q <= s_axis_tuser;
                        state_q <= s_axis_tlast ? FLUSH : RUN;
                    end
                end
                RUN: begin
                    if (push && s_axis_tlast) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (pop && m_last_int) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_axis_tready = s_ready_int;
    assign m_axis_tvalid = m_valid_int;
    assign m_axis_tlast  = m_last_int;
    assign m_axis_tdata  = areset ? '0 : acc_q[OUT_WIDTH-1:0];
    assign m_axis_tcount = areset ? '0 : out_cnt[CW-1:0];
    assign m_axis_tuser  = areset ? 4'd0 : tuser_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_tx_puncturer.sv
// Bench for tx_puncturer (WIDTH=4, OUT_WIDTH=8): directed packets with
// hand-computed beats, then random packets scored against a bit-level model.
module tb_tx_puncturer;

    localparam int WIDTH     = 4;
    localparam int OUT_WIDTH = 8;
    localparam int CW        = $clog2(OUT_WIDTH + 1);
    localparam int SW        = 4 + 1 + CW + OUT_WIDTH;

    logic                 aclk = 1'b0;
    logic                 areset = 1'b1;
    logic [2*WIDTH-1:0]   s_axis_tdata = '0;
    logic                 s_axis_tvalid = 1'b0;
    logic                 s_axis_tready;
    logic                 s_axis_tlast = 1'b0;
    logic [3:0]           s_axis_tuser = '0;
    logic [OUT_WIDTH-1:0] m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready = 1'b1;
    logic                 m_axis_tlast;
    logic [3:0]           m_axis_tuser;
    logic [CW-1:0]        m_axis_tcount;
    logic [1:0]           dbg_state;

    logic [SW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    bit            rand_ready = 1'b0;

    // clock / reset
    always #5 aclk = ~aclk;

    tx_puncturer #(
        .WIDTH     (WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tcount (m_axis_tcount),
        .dbg_state_o   (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] pack_beat(input logic [3:0] user, input logic last,
                                                input int cnt, input logic [7:0] data);
        pack_beat = {user, last, CW'(cnt), data};
    endfunction

    // scoreboard: every output pop is compared with the head of exp_q
    always @(negedge aclk) begin
        if (!areset && m_axis_tvalid && m_axis_tready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_beat: observed=%h expected=none",
                       {m_axis_tuser, m_axis_tlast, m_axis_tcount, m_axis_tdata});
            end
            if (exp_q.size() > 0)
                check("out_beat", {m_axis_tuser, m_axis_tlast, m_axis_tcount, m_axis_tdata},
                      exp_q.pop_front());
        end
    end

    // driver tasks: each enters and leaves at posedge+2
    task automatic step();
        @(posedge aclk);
        #2;
        if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic [3:0] user);
        int n = 0;
        bit taken = 1'b0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        while (!taken && n < 200) begin
            #1;
            taken = s_axis_tready;
            #(-1 + 1);
            @(posedge aclk);
            #2;
            n++;
            if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (!taken) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed=stalled expected=accepted");
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            step();
            n++;
        end
        m_axis_tready = 1'b1;
        step();
        check("drain_left", exp_q.size(), 0);
        check("drain_idle", dbg_state, 0);
    endtask

    // reference model: puncture patterns as written, phase = pair index mod period
    task automatic random_packet();
        int         len;
        logic [1:0] r;
        logic [3:0] user;
        int         eff, per, k, cnt;
        logic [7:0] beats[$];
        bit         bits[$];
        logic [7:0] d;
        int pa[3][3] = '{'{1, 0, 0}, '{1, 1, 0}, '{1, 1, 0}};
        int pb[3][3] = '{'{1, 0, 0}, '{1, 0, 0}, '{1, 0, 1}};
        len  = $urandom_range(1, 6);
        r    = 2'($urandom_range(0, 3));
        user = {2'($urandom_range(0, 3)), r};
        eff  = (r == 2'd3) ? 0 : int'(r);
        per  = eff + 1;
        k    = 0;
        for (int b = 0; b < len; b++) begin
            d = 8'($urandom);
            beats.push_back(d);
            for (int p = 0; p < WIDTH; p++) begin
                if (pa[eff][k % per] == 1) bits.push_back(d[2*p]);
                if (pb[eff][k % per] == 1) bits.push_back(d[2*p+1]);
                k++;
            end
        end
        for (int s = 0; s < bits.size(); s += OUT_WIDTH) begin
            cnt = (bits.size() - s < OUT_WIDTH) ? bits.size() - s : OUT_WIDTH;
            d = '0;
            for (int j = 0; j < cnt; j++) d[j] = bits[s + j];
            exp_q.push_back(pack_beat(user, (s + OUT_WIDTH >= bits.size()), cnt, d));
        end
        for (int b = 0; b < len; b++) send_beat(beats[b], (b == len - 1), user);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset: outputs held at zero
        repeat (3) @(posedge aclk);
        #5;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tcount", m_axis_tcount, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_s_tready", s_axis_tready, 0);
        @(posedge aclk);
        #2;
        areset = 1'b0;
        #1;
        check("post_rst_s_tready", s_axis_tready, 1);
        check("post_rst_state", dbg_state, 0);
        #(-1 + 1);
        step();

        // rate 1/2, two beats
        exp_q.push_back(pack_beat(4'hC, 1'b0, 8, 8'hA5));
        exp_q.push_back(pack_beat(4'hC, 1'b1, 8, 8'h3C));
        send_beat(8'hA5, 1'b0, 4'hC);
        send_beat(8'h3C, 1'b1, 4'hC);
        drain();

        // rate 2/3, single beat
        exp_q.push_back(pack_beat(4'h5, 1'b1, 6, 8'h3F));
        send_beat(8'hFF, 1'b1, 4'h5);
        drain();

        // rate 3/4, three beats -> 16 bits
        exp_q.push_back(pack_beat(4'hA, 1'b0, 8, 8'hFF));
        exp_q.push_back(pack_beat(4'hA, 1'b1, 8, 8'hFF));
        send_beat(8'hFF, 1'b0, 4'hA);
        send_beat(8'hFF, 1'b0, 4'hA);
        send_beat(8'hFF, 1'b1, 4'hA);
        drain();

        // backpressure mid-packet, rate 1/2
        for (int i = 1; i <= 6; i++)
            exp_q.push_back(pack_beat(4'h4, (i == 6), 8, 8'(i * 8'h11)));
        send_beat(8'h11, 1'b0, 4'h4);
        send_beat(8'h22, 1'b0, 4'h4);
        m_axis_tready = 1'b0;
        #1;
        check("stall_s_tready_start", s_axis_tready, 0);
        check("stall_tvalid", m_axis_tvalid, 1);
        check("stall_tdata_start", m_axis_tdata, 8'h22);
        #(-1 + 1);
        repeat (10) step();
        #1;
        check("stall_s_tready_end", s_axis_tready, 0);
        check("stall_tdata_end", m_axis_tdata, 8'h22);
        #(-1 + 1);
        m_axis_tready = 1'b1;
        for (int i = 3; i <= 6; i++) send_beat(8'(i * 8'h11), (i == 6), 4'h4);
        drain();

        // reset mid-packet, then a clean rate 1/2 packet
        send_beat(8'h5A, 1'b0, 4'h2);
        areset = 1'b1;
        step();
        areset = 1'b0;
        #3;
        check("abort_tvalid", m_axis_tvalid, 0);
        check("abort_state", dbg_state, 0);
        check("abort_s_tready", s_axis_tready, 1);
        #(-3 + 3);
        step();
        exp_q.push_back(pack_beat(4'h0, 1'b1, 8, 8'h5A));
        send_beat(8'h5A, 1'b1, 4'h0);
        drain();

        // reserved rate behaves as 1/2
        exp_q.push_back(pack_beat(4'h3, 1'b1, 8, 8'h96));
        send_beat(8'h96, 1'b1, 4'h3);
        drain();

        // random packets with random output backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) random_packet();
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
